// File: rtl/ft_tmr_voter_mon.sv
// TMR voter with per-replica fault monitoring: votes three WIDTH-bit replicas,
// tracks mismatch runs, and degrades TMR -> DEGRADED -> FATAL as replicas fail.

module ft_tmr_vote_lane #(
  parameter int WIDTH = 8
) (
  input  logic [3*WIDTH-1:0] data,
  input  logic               degr,
  input  logic [1:0]         sel,
  output logic [WIDTH-1:0]   v
);
  logic [WIDTH-1:0] a, b, c, pick;

  assign a = data[0*WIDTH +: WIDTH];
  assign b = data[1*WIDTH +: WIDTH];
  assign c = data[2*WIDTH +: WIDTH];
  assign pick = (sel == 2'd1) ? b : (sel == 2'd2) ? c : a;
  assign v = degr ? pick : ((a & b) | (a & c) | (b & c));
endmodule

module ft_tmr_voter_mon #(
  parameter int WIDTH       = 8,
  parameter int VOTE_SET    = 1,
  parameter int PERM_THRESH = 4,
  parameter int CNT_W       = 8,
  parameter int OUT_REG     = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  input  logic                 clear_i,
  input  logic [3*WIDTH-1:0]   data_i,
  output logic [3*WIDTH-1:0]   data_o,
  output logic                 err_o,
  output logic [2:0]           err_rep_o,
  output logic [2:0]           fail_o,
  output logic [CNT_W-1:0]     err_cnt_o,
  output logic [1:0]           state_o,
  output logic                 fatal_o
);
  localparam int NV = (VOTE_SET == 2) ? 3 : 1;
  localparam logic [CNT_W:0] THR = (CNT_W+1)'(PERM_THRESH);

  typedef enum logic [1:0] {ST_TMR = 2'b00, ST_DEG = 2'b01, ST_FATAL = 2'b10} state_t;

  state_t                    state;
  logic [2:0][WIDTH-1:0]     rep;
  logic [NV-1:0][WIDTH-1:0]  vote;
  logic [3*WIDTH-1:0]        voted;
  logic [2:0]                fail, err_rep, fail_set, fail_nxt;
  logic [2:0][CNT_W-1:0]     run;
  logic [CNT_W-1:0]          err_cnt;
  logic [1:0]                sel, nfail_nxt;
  logic                      degr, pair_mis;

  assign rep  = data_i;
  assign degr = (state != ST_TMR);

  // Once degraded, the voted copy is the lowest-index replica still trusted.
  always_comb begin
    sel = 2'd0;
    if (fail[0]) sel = fail[1] ? (fail[2] ? 2'd0 : 2'd2) : 2'd1;
  end

  always_comb begin
    pair_mis = 1'b0;
    case (fail)
      3'b001:  pair_mis = (rep[1] != rep[2]);
      3'b010:  pair_mis = (rep[0] != rep[2]);
      3'b100:  pair_mis = (rep[0] != rep[1]);
      default: pair_mis = 1'b0;
    endcase
  end

  generate
    if (VOTE_SET == 0) begin : g_bypass
      assign vote[0] = rep[0];
      assign voted   = {3{rep[0]}};
      assign err_rep = '0;
    end else begin : g_vote
      for (genvar g = 0; g < NV; g++) begin : g_lane
        ft_tmr_vote_lane #(.WIDTH(WIDTH)) u_lane (
          .data(data_i), .degr(degr), .sel(sel), .v(vote[g])
        );
      end
      if (NV == 3) begin : g_tri
        assign voted = vote;
      end else begin : g_single
        assign voted = {3{vote[0]}};
      end
      // With one replica out, a disagreement between the survivors cannot be
      // resolved, so it is charged to both of them.
      always_comb begin
        err_rep = '0;
        if (degr) err_rep = ~fail & {3{pair_mis}};
        else for (int k = 0; k < 3; k++) err_rep[k] = |(rep[k] ^ vote[0]);
      end
    end

    if (OUT_REG != 0) begin : g_oreg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) data_o <= '0;
        else     data_o <= voted;
      end
    end else begin : g_ocomb
      assign data_o = voted;
    end
  endgenerate

  assign err_o     = |err_rep;
  assign err_rep_o = err_rep;

  always_comb begin
    for (int k = 0; k < 3; k++)
      fail_set[k] = en_i & ~fail[k] & err_rep[k] & (({1'b0, run[k]} + 1'b1) >= THR);
  end
  assign fail_nxt  = fail | fail_set;
  assign nfail_nxt = {1'b0, fail_nxt[0]} + {1'b0, fail_nxt[1]} + {1'b0, fail_nxt[2]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_TMR;
      fail    <= '0;
      run     <= '0;
      err_cnt <= '0;
    end else if (clear_i) begin
      state   <= ST_TMR;
      fail    <= '0;
      run     <= '0;
      err_cnt <= '0;
    end else if (en_i) begin
      if (err_o && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
      for (int k = 0; k < 3; k++) begin
        if (fail[k] || !err_rep[k]) run[k] <= '0;
        else if (!(&run[k]))        run[k] <= run[k] + 1'b1;
      end
      fail <= fail_nxt;
      case (state)
        ST_TMR: begin
          if (nfail_nxt >= 2'd2)      state <= ST_FATAL;
          else if (nfail_nxt == 2'd1) state <= ST_DEG;
        end
        ST_DEG:   if (nfail_nxt >= 2'd2) state <= ST_FATAL;
        ST_FATAL: state <= ST_FATAL;
        default:  state <= ST_TMR;
      endcase
    end
  end

  assign fail_o    = fail;
  assign err_cnt_o = err_cnt;
  assign state_o   = state;
  assign fatal_o   = (state == ST_FATAL);
endmodule
